seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display, placed directly downstream of the stopwatch counter. It takes the four BCD digits (MM:SS), snapshots them once per scan frame, and drives one digit at a time through registered active-low anode, segment and decimal-point outputs. A programmable blanking gap at the start of each digit slot suppresses ghosting between digits.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/bcd_to_seg7.sv | 25 ++
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 tb/tb_seg7_scan_driver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the stopwatch seven-segment display path:
// active-low glyphs (seg[0]=a .. seg[6]=g), digit slot indices and the MM.SS separator slot.
package seg7_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [3:0] AN_OFF = 4'b1111;

   localparam digit_idx_t DIG_SEC_ONES = 2'd0;
   localparam digit_idx_t DIG_SEC_TENS = 2'd1;
   localparam digit_idx_t DIG_MIN_ONES = 2'd2;
   localparam digit_idx_t DIG_MIN_TENS = 2'd3;

   // The separator dot is lit on minutes-ones, so the display reads MM.SS
   localparam digit_idx_t DP_DIGIT = 2'd2;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-low seven-segment decoder; non-decimal codes render as a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver with per-frame input snapshot and blanking gap.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] seconds_ones,
   input  logic [3:0] seconds_tens,
   input  logic [3:0] minutes_ones,
   input  logic [3:0] minutes_tens,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] r_reg, r_next;
   digit_idx_t    idx_reg, idx_next;
   logic [15:0]   snap_reg, snap_next;
   logic [3:0]    an_reg, an_next;
   logic [6:0]    seg_reg, seg_next;
   logic          dp_reg, dp_next;

   logic          slot_end;
   logic          frame_end;
   logic          in_blank;
   logic          digit_off;
   logic [3:0]    digit;
   logic [6:0]    glyph;

   always_comb begin
      slot_end  = (r_reg == R_LAST);
      frame_end = slot_end && (idx_reg == DIG_MIN_TENS);
      r_next    = slot_end ? '0 : r_reg + 1'b1;
      idx_next  = slot_end ? idx_reg + 2'd1 : idx_reg;
      // Inputs are only sampled between frames so a frame never mixes two times
      snap_next = frame_end ? {minutes_tens, minutes_ones, seconds_tens, seconds_ones}
                            : snap_reg;
   end

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign in_blank = 1'b0;
      end else begin : g_blank
         localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES);
         assign in_blank = (r_reg < BLANK_LAST);
      end
   endgenerate

   always_comb begin
      digit = 4'd0;
      case (idx_reg)
         DIG_SEC_ONES: digit = snap_reg[3:0];
         DIG_SEC_TENS: digit = snap_reg[7:4];
         DIG_MIN_ONES: digit = snap_reg[11:8];
         DIG_MIN_TENS: digit = snap_reg[15:12];
         default:      digit = 4'd0;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   assign digit_off = (idx_reg == DIG_MIN_TENS) && (snap_reg[15:12] == 4'd0);
`else
   assign digit_off = 1'b0;
`endif

   bcd_to_seg7 u_decode (
      .bcd (digit),
      .seg (glyph)
   );

   always_comb begin
      an_next  = AN_OFF;
      seg_next = SEG_OFF;
      dp_next  = 1'b1;
      if (!in_blank && !digit_off) begin
         an_next  = ~(4'b0001 << idx_reg);
         seg_next = glyph;
         dp_next  = (idx_reg != DP_DIGIT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg    <= '0;
         idx_reg  <= DIG_SEC_ONES;
         snap_reg <= '0;
         an_reg   <= AN_OFF;
         seg_reg  <= SEG_OFF;
         dp_reg   <= 1'b1;
      end else begin
         r_reg    <= r_next;
         idx_reg  <= idx_next;
         snap_reg <= snap_next;
         an_reg   <= an_next;
         seg_reg  <= seg_next;
         dp_reg   <= dp_next;
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
   assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2) against a time-based display model.
module tb_seg7_scan_driver;

   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 4 * RD;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] seconds_ones, seconds_tens, minutes_ones, minutes_tens;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks = 0;
   int errors = 0;
   int n;
   logic [15:0] hist [0:8191];

   always #5 clk = ~clk;

   seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk          (clk),
      .rst          (rst),
      .seconds_ones (seconds_ones),
      .seconds_tens (seconds_tens),
      .minutes_ones (minutes_ones),
      .minutes_tens (minutes_tens),
      .an           (an),
      .seg          (seg),
      .dp           (dp)
   );

   function automatic logic [6:0] glyph_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Output after edge k reflects counter step k-1; frame f shows the inputs seen at edge 32*f.
   task automatic check_model(input string tag);
      int s, slot, pos, f;
      logic [15:0] v;
      logic [3:0] d, e_an;
      logic [6:0] e_seg;
      logic e_dp;
      logic off;
      s    = n - 1;
      slot = (s / RD) % 4;
      pos  = s % RD;
      f    = s / FRAME;
      v    = (f == 0) ? 16'h0000 : hist[f * FRAME];
      d    = v[slot*4 +: 4];
      off  = (pos < BC);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 3 && d == 4'd0) off = 1'b1;
`endif
      if (off) begin
         e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         e_an  = ~(4'b0001 << slot);
         e_seg = glyph_of(d);
         e_dp  = (slot == 2) ? 1'b0 : 1'b1;
      end
      checks += 3;
      assert (an === e_an) else begin
         errors++;
         $error("FAIL %s an edge=%0d got %b exp %b", tag, n, an, e_an);
      end
      assert (seg === e_seg) else begin
         errors++;
         $error("FAIL %s seg edge=%0d got %b exp %b", tag, n, seg, e_seg);
      end
      assert (dp === e_dp) else begin
         errors++;
         $error("FAIL %s dp edge=%0d got %b exp %b", tag, n, dp, e_dp);
      end
      $display("edge=%0d slot=%0d an=%b seg=%b dp=%b", n, slot, an, seg, dp);
   endtask

   task automatic check_reset(input string tag);
      checks += 3;
      assert (an === 4'b1111) else begin
         errors++;
         $error("FAIL %s an got %b exp 1111", tag, an);
      end
      assert (seg === 7'h7F) else begin
         errors++;
         $error("FAIL %s seg got %b exp 1111111", tag, seg);
      end
      assert (dp === 1'b1) else begin
         errors++;
         $error("FAIL %s dp got %b exp 1", tag, dp);
      end
      $display("reset %s an=%b seg=%b dp=%b", tag, an, seg, dp);
   endtask

   task automatic tick(input string tag);
      logic [15:0] rec;
      rec = {minutes_tens, minutes_ones, seconds_tens, seconds_ones};
      @(posedge clk);
      n++;
      hist[n] = rec;
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      rst = 1'b1;
      {minutes_tens, minutes_ones, seconds_tens, seconds_ones} = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("por");

      {minutes_tens, minutes_ones, seconds_tens, seconds_ones} = 16'h1234;
      rst = 1'b0;
      n = 0;
      while (n < 39) tick("frame0_1234");
      seconds_tens = 4'd5;
      while (n < 3 * FRAME) tick("tens_change");

      seconds_ones = 4'hA;
      repeat (2 * FRAME) tick("dash");

      minutes_tens = 4'd0;
      repeat (2 * FRAME) tick("lead_zero");

      // Pulse reset while slot 2 (minutes-ones) is being driven
      while ((n % FRAME) != 2 * RD + 4) tick("to_slot2");
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("mid_scan");
      rst = 1'b0;
      n = 0;
      repeat (3) tick("restart");
      checks++;
      assert (an === 4'b1110) else begin
         errors++;
         $error("FAIL restart_an got %b exp 1110", an);
      end
      repeat (2 * FRAME) tick("restart_frames");

      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0: seconds_ones = 4'($urandom_range(0, 15));
               1: seconds_tens = 4'($urandom_range(0, 15));
               2: minutes_ones = 4'($urandom_range(0, 15));
               default: minutes_tens = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            endcase
         end
         tick("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
